config_sequencer: RTL and testbench



---
 rtl/config_sequencer_pkg.sv | 38 +++
 rtl/cfg_byte_ram.sv | 32 +++
 rtl/config_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_config_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/config_sequencer_pkg.sv
// Shared types and helpers for the config bus sequencer.
package config_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GAP,
    ST_SEND,
    ST_TAIL
  } cseq_state_t;

  // configId that no block owns; seeing it resets every block's byte counter.
  localparam logic [7:0] DEFAULT_IDLE_ID = 8'hFF;

  // Upper bound on block count that the block search can handle.
  localparam int MAX_BLOCKS = 64;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } blk_sel_t;

  // Lowest block index >= cur whose length is nonzero.
  // Bit i of lens is set when block i has a nonzero length.
  function automatic blk_sel_t next_block(input logic [MAX_BLOCKS-1:0] lens, input int cur);
    blk_sel_t r;
    r = '0;
    for (int i = MAX_BLOCKS - 1; i >= 0; i--) begin
      if (lens[i] && (i >= cur)) begin
        r.found = 1'b1;
        r.idx   = 6'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cfg_byte_ram.sv
// Firmware byte store: one write port, one registered read port.
// The read register returns 0 when no read is issued, so the config bus
// data is 0 for every cycle that is not a SEND cycle.
module cfg_byte_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register, cleared when idle so it can drive the bus directly.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= 8'h00;
    else if (re) rdata <= mem[raddr];
    else         rdata <= 8'h00;
  end

endmodule

// File: rtl/config_sequencer.sv
// Buffers per-block firmware bytes and, on command, drops tracing, drains
// the pipeline and streams each block's bytes over the config bus.
//
//   state | meaning
//   IDLE  | host writes accepted, tracing follows tracing_req
//   DRAIN | tracing low, waiting for in-flight data to leave the pipe
//   GAP   | one idle-id cycle before a block; reads byte 0
//   SEND  | one byte per cycle for the current block, prefetching the next
//   TAIL  | one idle-id cycle after the last block
module config_sequencer
  import config_seq_pkg::*;
#(
  parameter int         NUM_BLOCKS   = 8,
  parameter logic [7:0] ID_BASE      = 8'd1,
  parameter logic [7:0] IDLE_ID      = DEFAULT_IDLE_ID,
  parameter int         MAX_BYTES    = 16,
  parameter int         DRAIN_CYCLES = 4,
  localparam int        BW           = $clog2(NUM_BLOCKS),
  localparam int        AW           = $clog2(MAX_BYTES),
  localparam int        LW           = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_block,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          len_wr_en,
  input  logic [LW-1:0] len_data,
  output logic          wr_ready,
  input  logic          cmd_valid,
  input  logic          cmd_all,
  input  logic [BW-1:0] cmd_block,
  output logic          cmd_ready,
  input  logic          tracing_req,
  output logic          tracing,
  output logic [7:0]    configId,
  output logic [7:0]    configData,
  output logic          busy,
  output logic          done
);

  localparam int DW  = $clog2(DRAIN_CYCLES + 1);
  localparam int RAW = $clog2(NUM_BLOCKS * MAX_BYTES);

  cseq_state_t state_q, state_d;
  logic [BW-1:0] blk_q, blk_d, cmd_blk_q;
  logic [AW-1:0] idx_q, idx_d, rd_idx;
  logic [DW-1:0] drain_q, drain_d;
  logic all_q, accept, rd_en, last_byte, ram_we;
  logic [LW-1:0] len_q [NUM_BLOCKS];
  logic [LW-1:0] len_sat;
  logic [MAX_BLOCKS-1:0] lens_nz;
  blk_sel_t first_sel, next_sel;
  logic [RAW-1:0] ram_waddr, ram_raddr;

  assign accept    = cmd_valid && cmd_ready;
  assign ram_we    = wr_en && wr_ready;
  assign len_sat   = (len_data > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : len_data;
  assign last_byte = (LW'(idx_q) + LW'(1)) == len_q[blk_q];
  assign ram_waddr = RAW'(wr_block) * RAW'(MAX_BYTES) + RAW'(wr_addr);
  assign ram_raddr = RAW'(blk_q) * RAW'(MAX_BYTES) + RAW'(rd_idx);

  // Nonzero-length mask used to pick the first and following blocks.
  always_comb begin
    lens_nz = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) lens_nz[i] = (len_q[i] != '0);
  end

  assign first_sel = next_block(lens_nz, 0);
  assign next_sel  = next_block(lens_nz, int'(blk_q) + 1);

  // Block length registers, written only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) len_q[i] <= '0;
    end else if (len_wr_en && wr_ready) begin
      len_q[wr_block] <= len_sat;
    end
  end

  // Next-state, block/byte selection and RAM read request.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    rd_idx  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          if (all_q) begin
            blk_d   = BW'(first_sel.idx);
            state_d = first_sel.found ? ST_GAP : ST_TAIL;
          end else begin
            blk_d   = cmd_blk_q;
            state_d = (len_q[cmd_blk_q] != '0) ? ST_GAP : ST_TAIL;
          end
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_GAP: begin
        rd_en   = 1'b1;
        rd_idx  = '0;
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (last_byte) begin
          if (all_q && next_sel.found) begin
            blk_d   = BW'(next_sel.idx);
            state_d = ST_GAP;
          end else begin
            state_d = ST_TAIL;
          end
        end else begin
          rd_en  = 1'b1;
          rd_idx = idx_q + AW'(1);
          idx_d  = idx_q + AW'(1);
        end
      end
      ST_TAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counters and latched command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      blk_q     <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      all_q     <= 1'b0;
      cmd_blk_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      if (accept) begin
        all_q     <= cmd_all;
        cmd_blk_q <= cmd_block;
      end
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      tracing   <= 1'b0;
      configId  <= IDLE_ID;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ready  <= 1'b1;
      cmd_ready <= 1'b1;
    end else begin
      tracing   <= (state_d == ST_IDLE) && tracing_req;
      configId  <= (state_d == ST_SEND) ? ID_BASE + 8'(blk_d) : IDLE_ID;
      busy      <= state_d != ST_IDLE;
      done      <= state_q == ST_TAIL;
      wr_ready  <= state_d == ST_IDLE;
      cmd_ready <= state_d == ST_IDLE;
    end
  end

  cfg_byte_ram #(
    .DEPTH(NUM_BLOCKS * MAX_BYTES),
    .AW   (RAW)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(wr_data),
    .re   (rd_en),
    .raddr(ram_raddr),
    .rdata(configData)
  );

endmodule

// File: tb/tb_config_sequencer.sv
// Bench for config_sequencer: table of commands checked cycle by cycle
// against an expected bus trace, plus hand sequences for corner cases.
module tb_config_sequencer;

  localparam int NB = 4;
  localparam int MB = 8;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, len_wr_en, cmd_valid, cmd_all, tracing_req;
  logic [1:0] wr_block, cmd_block;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] len_data;
  logic       wr_ready, cmd_ready, tracing, busy, done;
  logic [7:0] configId, configData;

  always #5 clk = ~clk;

  config_sequencer #(
    .NUM_BLOCKS(NB), .ID_BASE(8'd1), .IDLE_ID(8'hFF),
    .MAX_BYTES(MB), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_block(wr_block), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_wr_en(len_wr_en), .len_data(len_data), .wr_ready(wr_ready),
    .cmd_valid(cmd_valid), .cmd_all(cmd_all), .cmd_block(cmd_block), .cmd_ready(cmd_ready),
    .tracing_req(tracing_req), .tracing(tracing),
    .configId(configId), .configData(configData), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
    logic       busy;
    logic       trc;
    logic       done;
  } beat_t;

  typedef struct packed {
    logic [15:0] lens;     // nibble i = len_data written to block i
    logic        all;
    logic [1:0]  blk;
    logic        treq;
    logic [7:0]  exp_lat;  // cycles from accept to done
  } vec_t;

  beat_t      sb[$];
  logic [7:0] mmem [NB][MB];
  int         mlen [NB];
  vec_t       vecs [7];
  int         tests = 0;
  int         fails = 0;
  int         lat;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [7:0] id, input logic [7:0] d,
                               input logic b, input logic t, input logic dn);
    beat_t r;
    r.id = id; r.data = d; r.busy = b; r.trc = t; r.done = dn;
    return r;
  endfunction

  task automatic wr_byte(input int b, input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_block = 2'(b); wr_addr = 3'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mmem[b][a] = d;
  endtask

  task automatic wr_len(input int b, input int l);
    len_wr_en = 1'b1; wr_block = 2'(b); len_data = 4'(l);
    @(negedge clk);
    len_wr_en = 1'b0;
    mlen[b] = (l > MB) ? MB : l;
  endtask

  // Expected bus trace for a command accepted this cycle, one beat per cycle.
  task automatic push_expect(input logic all, input logic [1:0] blk, input logic treq);
    for (int i = 0; i < DC; i++) sb.push_back(mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0));
    for (int b = 0; b < NB; b++) begin
      if ((all || b == int'(blk)) && mlen[b] > 0) begin
        sb.push_back(mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < mlen[b]; k++) sb.push_back(mk(8'(1 + b), mmem[b][k], 1'b1, 1'b0, 1'b0));
      end
    end
    sb.push_back(mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(8'hFF, 8'h00, 1'b0, treq, 1'b1));
  endtask

  task automatic issue(input logic all, input logic [1:0] blk, input logic treq);
    check("cmd_ready before issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_all = all; cmd_block = blk; tracing_req = treq;
    push_expect(all, blk, treq);
  endtask

  task automatic run_trace(input string nm, input int max_beats, input bit hold, output int lt);
    beat_t bt;
    int    c;
    lt = -1;
    c  = 0;
    while (sb.size() > 0 && c < max_beats) begin
      @(negedge clk);
      c++;
      bt = sb.pop_front();
      check($sformatf("%s c%0d configId", nm, c), configId, bt.id);
      check($sformatf("%s c%0d configData", nm, c), configData, bt.data);
      check($sformatf("%s c%0d busy", nm, c), busy, bt.busy);
      check($sformatf("%s c%0d tracing", nm, c), tracing, bt.trc);
      check($sformatf("%s c%0d done", nm, c), done, bt.done);
      if (done === 1'b1 && lt < 0) lt = c;
      if (c == 1) begin
        if (!hold) cmd_valid = 1'b0;
        wr_en = 1'b0;
        len_wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{lens: 16'h0300, all: 1'b0, blk: 2'd2, treq: 1'b1, exp_lat: 8'd10};
    vecs[1] = '{lens: 16'h0102, all: 1'b1, blk: 2'd0, treq: 1'b0, exp_lat: 8'd11};
    vecs[2] = '{lens: 16'h0000, all: 1'b1, blk: 2'd0, treq: 1'b1, exp_lat: 8'd6};
    vecs[3] = '{lens: 16'h8F8C, all: 1'b1, blk: 2'd0, treq: 1'b1, exp_lat: 8'd42};
    vecs[4] = '{lens: 16'h0050, all: 1'b0, blk: 2'd0, treq: 1'b0, exp_lat: 8'd6};
    vecs[5] = '{lens: 16'h7001, all: 1'b0, blk: 2'd3, treq: 1'b1, exp_lat: 8'd14};
    vecs[6] = '{lens: 16'h1000, all: 1'b1, blk: 2'd0, treq: 1'b0, exp_lat: 8'd8};

    reset = 1'b1; wr_en = 0; len_wr_en = 0; cmd_valid = 0; cmd_all = 0; tracing_req = 0;
    wr_block = 0; cmd_block = 0; wr_addr = 0; wr_data = 0; len_data = 0;
    for (int b = 0; b < NB; b++) mlen[b] = 0;

    repeat (3) @(negedge clk);
    check("reset configId", configId, 8'hFF);
    check("reset configData", configData, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset tracing", tracing, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset wr_ready", wr_ready, 1);
    check("post-reset cmd_ready", cmd_ready, 1);
    check("post-reset busy", busy, 0);

    for (int b = 0; b < NB; b++)
      for (int k = 0; k < MB; k++) wr_byte(b, k, 8'h40 + 8'(b * 16 + k));
    wr_byte(2, 0, 8'h11);
    wr_byte(2, 1, 8'h22);
    wr_byte(2, 2, 8'h33);

    // tracing follows tracing_req one cycle later while idle
    tracing_req = 1'b1;
    @(negedge clk);
    check("idle tracing rise", tracing, 1);
    tracing_req = 1'b0;
    @(negedge clk);
    check("idle tracing fall", tracing, 0);

    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < NB; b++) wr_len(b, int'(vecs[v].lens[b*4 +: 4]));
      issue(vecs[v].all, vecs[v].blk, vecs[v].treq);
      run_trace($sformatf("vec%0d", v), 200, 1'b0, lat);
      check($sformatf("vec%0d done latency", v), lat, 32'(vecs[v].exp_lat));
    end

    // cmd_valid held through a command, plus a write while busy
    wr_len(0, 0); wr_len(1, 2); wr_len(2, 0); wr_len(3, 0);
    issue(1'b0, 2'd1, 1'b0);
    run_trace("held_a", 1, 1'b1, lat);
    check("busy wr_ready", wr_ready, 0);
    check("busy cmd_ready", cmd_ready, 0);
    wr_en = 1'b1; wr_block = 2'd1; wr_addr = 3'd0; wr_data = 8'hEE;
    run_trace("held_b", 1, 1'b1, lat);
    run_trace("held_c", 200, 1'b1, lat);
    push_expect(1'b0, 2'd1, 1'b0);
    run_trace("held_2", 200, 1'b0, lat);
    check("held second done latency", lat, 9);

    // reset on the second SEND cycle
    wr_len(0, 0); wr_len(1, 0); wr_len(2, 3); wr_len(3, 0);
    issue(1'b0, 2'd2, 1'b1);
    run_trace("rst_pre", 7, 1'b0, lat);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort configId", configId, 8'hFF);
    check("abort configData", configData, 0);
    check("abort tracing", tracing, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    reset = 1'b0;
    for (int b = 0; b < NB; b++) mlen[b] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort idle%0d done", i), done, 0);
      check($sformatf("abort idle%0d busy", i), busy, 0);
    end
    wr_len(2, 3);
    issue(1'b0, 2'd2, 1'b1);
    run_trace("rst_post", 200, 1'b0, lat);
    check("rst_post done latency", lat, 10);

    // write, length and command in the same idle cycle
    wr_len(2, 0);
    wr_en = 1'b1; wr_block = 2'd0; wr_addr = 3'd0; wr_data = 8'hAB;
    len_wr_en = 1'b1; len_data = 4'd1;
    mmem[0][0] = 8'hAB;
    mlen[0] = 1;
    issue(1'b0, 2'd0, 1'b0);
    run_trace("same_cycle", 200, 1'b0, lat);
    check("same_cycle done latency", lat, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
